led_share_arbiter: RTL and testbench
====================================

Name: led_share_arbiter

Overview:
- Round-robin arbiter that shares the single RGB LED between N requesters (timer taps, status monitors, debug sources).
- Sits between the timer-style tick/pattern generators and the LED driver pins.
- Guarantees each owner a minimum visible hold time, measured in ticks from a divided timer strobe.
- Inserts a blank gap between owners so that handovers are visible.

Parameters:
- N, 4, number of requesters (2..8).
- HOLD_TICKS, 8, minimum i_tick pulses an owner keeps the LED before it can be preempted (1..255).
- GAP_TICKS, 2, i_tick pulses of LED-off between owners (0..255; 0 means no gap state).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_tick  in  1  single-cycle timing strobe from the timer divider
- i_req  in  N  per-requester request level
- i_color  in  3N  per-requester colour; bits [3k+2:3k] = {r,g,b} of requester k
- o_grant  out  N  one-hot current owner; all zero when there is no owner
- o_rgb  out  3  colour to the LED driver; bit2=r, bit1=g, bit0=b
- o_busy  out  1  high in GRANT or GAP

Behaviour:
- Reset is asynchronous and active-low. Clock is i_clk. All state is registered on the rising edge.
- Reset values:
  - state=IDLE, o_grant=0, o_rgb=0, o_busy=0.
  - Hold and gap counters = 0.
  - RR pointer = N-1, so requester 0 has the highest priority first.
- Reset asserted mid-operation clears everything immediately, with no gap.
- RR selection: the first requester with i_req=1, searching from ptr+1 upward modulo N. On grant, ptr := the granted index.
- IDLE:
  - If any i_req: next cycle state=GRANT, o_grant=onehot(sel), hold counter=0.
  - Otherwise remain in IDLE with o_rgb=0.
- GRANT:
  - o_rgb is registered from the owner's i_color slice, so it lags i_color by one cycle. It tracks colour changes every cycle.
  - Each i_tick increments the hold counter, saturating at HOLD_TICKS.
  - Release when either:
    - (a) the owner's i_req=0, sampled any cycle (early release allowed), or
    - (b) the hold counter is at HOLD_TICKS and any other i_req=1.
  - On release: o_grant=0 and o_rgb=0 next cycle; go to GAP, or to IDLE if GAP_TICKS=0.
  - If the hold has expired and there are no other requesters, the owner keeps the LED indefinitely.
- GAP:
  - o_rgb=0, o_grant=0, o_busy=1.
  - Gap counter increments on each i_tick. Move to IDLE on the cycle the counter reaches GAP_TICKS.
  - Requests are ignored during GAP. A requester released by preemption may re-win in IDLE only if it is next in RR order.
- Simultaneous events:
  - The owner dropping i_req in the same cycle the hold expires counts as rule (a); the result is the same.
  - i_tick coincident with release does not extend the gap. The gap counter starts at 0 in the GAP state.
- Latency: from i_req rising in IDLE to o_grant=1 is 1 cycle; o_rgb is valid in that same cycle.
- Counter widths are sized to hold max(HOLD_TICKS, GAP_TICKS). No wrap: counters saturate.
- Invariant: o_grant is always zero or one-hot. o_rgb=0 whenever o_grant=0.

Test Plan:
1. Reset release, N=4, all i_req=0, 20 ticks -> o_grant=0000, o_rgb=000, o_busy=0 throughout.
2. Single requester: i_req=0001, colour0=3'b101 -> o_grant=0001 one cycle later with o_rgb=101. Drop i_req -> next cycle o_grant=0 and o_rgb=0, then GAP for exactly 2 ticks, then IDLE.
3. Preemption: req0 held, req2 asserted at tick 3 -> req0 keeps the grant until tick 8. Then 2-tick gap, then o_grant=0100 with o_rgb=colour2.
4. Round-robin fairness: i_req=1111 held continuously -> grant order 0,1,2,3,0. Each owner holds exactly 8 ticks; each handover has a 2-tick blank.
5. Asynchronous reset mid-GRANT: pulse i_rst_n low between clock edges -> o_grant, o_rgb and o_busy go to 0 without waiting for a clock edge. After release, requester 0 wins first.
6. GAP_TICKS=0, HOLD_TICKS=1: req1 and req3 held -> handover occurs the cycle after each tick with no blank. o_grant alternates 0010/1000 and is never two-hot.

Source files
------------

// File: rtl/led_share_arbiter_if.sv
// LED share arbiter bus: request/colour inputs and owner/LED outputs.
// The master side drives requests; the arbiter is the slave side.
interface led_share_arbiter_if #(
   parameter int N = 4
);
   logic           i_tick;
   logic [N-1:0]   i_req;
   logic [3*N-1:0] i_color;
   logic [N-1:0]   o_grant;
   logic [2:0]     o_rgb;
   logic           o_busy;

   modport master (
      output i_tick,
      output i_req,
      output i_color,
      input  o_grant,
      input  o_rgb,
      input  o_busy
   );

   modport slave (
      input  i_tick,
      input  i_req,
      input  i_color,
      output o_grant,
      output o_rgb,
      output o_busy
   );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the single RGB LED with a tick-based minimum hold
// and a blank gap between owners.
module led_share_arbiter #(
   parameter int N          = 4,
   parameter int HOLD_TICKS = 8,
   parameter int GAP_TICKS  = 2
) (
   input logic                i_clk,
   input logic                i_rst_n,
   led_share_arbiter_if.slave bus
);
   localparam int PW   = (N > 1) ? $clog2(N) : 1;
   localparam int MAXT = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
   localparam int CW   = $clog2(MAXT + 1);

   localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TICKS);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS) - CW'(1);
   localparam logic [PW-1:0] PTR_RST  = PW'(N - 1);
   localparam logic [N-1:0]  ONE      = N'(1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [CW-1:0] hold_cnt;
   logic [CW-1:0] gap_cnt;
   logic [N-1:0]  grant;
   logic [2:0]    rgb;
   logic          busy;

   logic [PW-1:0] sel;
   logic          any_req;
   logic          owner_req;
   logic          other_req;
   logic          expired;
   logic          release_now;
   logic [2:0]    sel_col;
   logic [2:0]    own_col;

   assign bus.o_grant = grant;
   assign bus.o_rgb   = rgb;
   assign bus.o_busy  = busy;

   // Walk downward so the closest requester after ptr is written last.
   always_comb begin
      int j;
      j       = 0;
      sel     = '0;
      any_req = 1'b0;
      for (int k = N; k >= 1; k--) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (bus.i_req[j]) begin
            sel     = PW'(j);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      sel_col     = bus.i_color[3*int'(sel) +: 3];
      own_col     = bus.i_color[3*int'(ptr) +: 3];
      owner_req   = |(bus.i_req & grant);
      other_req   = |(bus.i_req & ~grant);
      expired     = (hold_cnt == HOLD_MAX);
      release_now = !owner_req || (expired && other_req);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         ptr      <= PTR_RST;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         grant    <= '0;
         rgb      <= '0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               rgb <= '0;
               if (any_req) begin
                  state    <= GRANT;
                  grant    <= ONE << sel;
                  rgb      <= sel_col;
                  ptr      <= sel;
                  hold_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            GRANT: begin
               if (release_now) begin
                  grant    <= '0;
                  rgb      <= '0;
                  hold_cnt <= '0;
                  gap_cnt  <= '0;
                  if (GAP_TICKS == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end else begin
                  rgb <= own_col;
                  if (bus.i_tick && !expired)
                     hold_cnt <= hold_cnt + CW'(1);
               end
            end
            GAP: begin
               if (bus.i_tick) begin
                  if (gap_cnt == GAP_LAST) begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     gap_cnt <= '0;
                  end else begin
                     gap_cnt <= gap_cnt + CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed and random checks of led_share_arbiter against a cycle model
// built from the owner/hold/gap rules.
module tb_led_share_arbiter;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   led_share_arbiter_if #(.N(4)) bus_a ();
   led_share_arbiter_if #(.N(4)) bus_b ();

   led_share_arbiter #(.N(4), .HOLD_TICKS(8), .GAP_TICKS(2)) dut_a (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus_a)
   );

   led_share_arbiter #(.N(4), .HOLD_TICKS(1), .GAP_TICKS(0)) dut_b (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus_b)
   );

   // mode: 0 nobody owns, 1 owned, 2 blank gap
   typedef struct {
      int         mode;
      int         own;
      int         last;
      int         ticks;
      int         gap;
      logic [7:0] grant;
      logic [2:0] rgb;
      logic       busy;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mreset(int n);
      mdl_t r;
      r.mode  = 0;
      r.own   = 0;
      r.last  = n - 1;
      r.ticks = 0;
      r.gap   = 0;
      r.grant = '0;
      r.rgb   = '0;
      r.busy  = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mstep(mdl_t m, logic tick, logic [7:0] req,
                                  logic [23:0] col, int n, int ht, int gt);
      mdl_t r;
      bit   found;
      bit   others;
      int   idx;
      r      = m;
      found  = 0;
      others = 0;
      if (m.mode == 0) begin
         r.rgb = '0;
         for (int k = 1; k <= n; k++) begin
            idx = (m.last + k) % n;
            if (!found && req[idx]) begin
               found   = 1;
               r.mode  = 1;
               r.own   = idx;
               r.last  = idx;
               r.ticks = 0;
               r.grant = 8'(1) << idx;
               r.rgb   = col[3*idx +: 3];
               r.busy  = 1'b1;
            end
         end
      end else if (m.mode == 1) begin
         for (int k = 0; k < n; k++)
            if (k != m.own && req[k]) others = 1;
         if (!req[m.own] || (m.ticks == ht && others)) begin
            r.grant = '0;
            r.rgb   = '0;
            r.ticks = 0;
            r.gap   = 0;
            r.mode  = (gt == 0) ? 0 : 2;
            r.busy  = (gt != 0);
         end else begin
            r.rgb = col[3*m.own +: 3];
            if (tick && m.ticks < ht) r.ticks = m.ticks + 1;
         end
      end else if (tick) begin
         if (m.gap + 1 >= gt) begin
            r.mode = 0;
            r.gap  = 0;
            r.busy = 1'b0;
         end else begin
            r.gap = m.gap + 1;
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= mreset(4);
         mb <= mreset(4);
      end else begin
         ma <= mstep(ma, bus_a.i_tick, {4'b0, bus_a.i_req},
                     {12'b0, bus_a.i_color}, 4, 8, 2);
         mb <= mstep(mb, bus_b.i_tick, {4'b0, bus_b.i_req},
                     {12'b0, bus_b.i_color}, 4, 1, 0);
      end
   end

   int n_asrt = 0;
   int n_fail = 0;
   int cyc    = 0;
   int tper   = 4;
   bit rnd_tick = 0;

   logic [3:0] pg = '0;
   logic       pb = 1'b0;
   logic       pt = 1'b0;
   int held = 0;
   int gapt = 0;
   int own_q[$];
   int hold_q[$];
   int gap_q[$];

   function automatic int oh2i(logic [3:0] g);
      int r;
      r = -1;
      for (int k = 0; k < 4; k++) if (g[k]) r = k;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [3:0] g;
      logic       b;
      logic       t;
      @(negedge clk);
      cyc++;
      chk("a_grant", {4'b0, bus_a.o_grant}, ma.grant);
      chk("a_rgb", {5'b0, bus_a.o_rgb}, {5'b0, ma.rgb});
      chk("a_busy", {7'b0, bus_a.o_busy}, {7'b0, ma.busy});
      chk("b_grant", {4'b0, bus_b.o_grant}, mb.grant);
      chk("b_rgb", {5'b0, bus_b.o_rgb}, {5'b0, mb.rgb});
      chk("b_busy", {7'b0, bus_b.o_busy}, {7'b0, mb.busy});
      chk("a_inv", {7'b0, $onehot0(bus_a.o_grant) &&
          (bus_a.o_grant != 0 || bus_a.o_rgb == 0)}, 8'd1);
      chk("b_inv", {7'b0, $onehot0(bus_b.o_grant) &&
          (bus_b.o_grant != 0 || bus_b.o_rgb == 0)}, 8'd1);
      g = bus_a.o_grant;
      b = bus_a.o_busy;
      if (pg != 0 && g == pg && pt) held++;
      if (pg == 0 && pb && pt) gapt++;
      if (pg != 0 && g == 0) begin
         hold_q.push_back(held);
         held = 0;
         gapt = 0;
      end
      if (g != 0 && g != pg) begin
         own_q.push_back(oh2i(g));
         held = 0;
      end
      if (pb && pg == 0 && !b) begin
         gap_q.push_back(gapt);
         gapt = 0;
      end
      pg = g;
      pb = b;
      if (rnd_tick) t = ($urandom_range(0, 3) == 0);
      else t = (cyc % tper == 0);
      bus_a.i_tick = t;
      bus_b.i_tick = t;
      pt = t;
   endtask

   task automatic wait_grant_a(input logic [3:0] tgt, input int maxc,
                               input string tag);
      int k;
      k = 0;
      while (bus_a.o_grant !== tgt && k < maxc) begin
         step();
         k++;
      end
      chk(tag, {4'b0, bus_a.o_grant}, {4'b0, tgt});
   endtask

   initial begin
      int k;
      int nb;
      int exp_own[5];
      bit seen;
      logic [3:0] lastb;
      logic [3:0] gb;
      logic [3:0] pgb;
      exp_own = '{0, 1, 2, 3, 0};
      rst_n = 1'b0;
      bus_a.i_tick = 1'b0;
      bus_a.i_req = '0;
      bus_a.i_color = '0;
      bus_b.i_tick = 1'b0;
      bus_b.i_req = '0;
      bus_b.i_color = '0;
      step();
      chk("rst_grant", {4'b0, bus_a.o_grant}, 8'h00);
      chk("rst_rgb", {5'b0, bus_a.o_rgb}, 8'h00);
      chk("rst_busy", {7'b0, bus_a.o_busy}, 8'h00);
      step();
      rst_n = 1'b1;

      // idle for 20 ticks
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (bus_a.o_grant != 0 || bus_a.o_rgb != 0 || bus_a.o_busy) seen = 1;
      end
      chk("t1_idle", {7'b0, seen}, 8'h00);

      // single requester, early release
      bus_a.i_color = 12'b000_000_000_101;
      bus_a.i_req = 4'b0001;
      step();
      chk("t2_grant", {4'b0, bus_a.o_grant}, 8'h01);
      chk("t2_rgb", {5'b0, bus_a.o_rgb}, 8'h05);
      for (int i = 0; i < 5; i++) step();
      bus_a.i_req = 4'b0000;
      step();
      chk("t2_rel_grant", {4'b0, bus_a.o_grant}, 8'h00);
      chk("t2_rel_rgb", {5'b0, bus_a.o_rgb}, 8'h00);
      chk("t2_rel_busy", {7'b0, bus_a.o_busy}, 8'h01);
      k = 0;
      while (bus_a.o_busy && k < 40) begin
         step();
         k++;
      end
      chk("t2_gap_end", {7'b0, bus_a.o_busy}, 8'h00);
      chk("t2_gap_ticks", 8'(gap_q.size() > 0 ? gap_q[$] : -1), 8'd2);

      // preemption after the hold expires
      bus_a.i_color = 12'b000_011_000_101;
      bus_a.i_req = 4'b0001;
      wait_grant_a(4'b0001, 20, "t3_first");
      k = 0;
      while (held < 3 && k < 40) begin
         step();
         k++;
      end
      bus_a.i_req = 4'b0101;
      wait_grant_a(4'b0100, 300, "t3_second");
      chk("t3_rgb", {5'b0, bus_a.o_rgb}, 8'h03);
      chk("t3_hold", 8'(hold_q.size() > 0 ? hold_q[$] : -1), 8'd8);
      chk("t3_gap", 8'(gap_q.size() > 0 ? gap_q[$] : -1), 8'd2);

      // round robin from a fresh reset
      rst_n = 1'b0;
      bus_a.i_req = '0;
      step();
      rst_n = 1'b1;
      own_q.delete();
      hold_q.delete();
      gap_q.delete();
      bus_a.i_color = 12'b110_011_010_101;
      bus_a.i_req = 4'b1111;
      k = 0;
      while (own_q.size() < 5 && k < 800) begin
         step();
         k++;
      end
      chk("t4_owners", 8'(own_q.size()), 8'd5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("t4_order%0d", i),
             8'(own_q.size() > i ? own_q[i] : -1), 8'(exp_own[i]));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_hold%0d", i),
             8'(hold_q.size() > i ? hold_q[i] : -1), 8'd8);
         chk($sformatf("t4_gap%0d", i),
             8'(gap_q.size() > i ? gap_q[i] : -1), 8'd2);
      end

      // asynchronous reset while owner 2 holds the LED
      wait_grant_a(4'b0100, 400, "t5_owner2");
      for (int i = 0; i < 3; i++) step();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_grant", {4'b0, bus_a.o_grant}, 8'h00);
      chk("t5_rgb", {5'b0, bus_a.o_rgb}, 8'h00);
      chk("t5_busy", {7'b0, bus_a.o_busy}, 8'h00);
      #1 rst_n = 1'b1;
      step();
      chk("t5_restart", {4'b0, bus_a.o_grant}, 8'h01);
      chk("t5_rgb0", {5'b0, bus_a.o_rgb}, 8'h05);

      // no-gap variant alternates between requesters 1 and 3
      bus_a.i_req = '0;
      bus_b.i_color = 12'b100_000_010_000;
      bus_b.i_req = 4'b1010;
      tper = 3;
      nb = 0;
      lastb = '0;
      pgb = bus_b.o_grant;
      for (int i = 0; i < 80; i++) begin
         step();
         gb = bus_b.o_grant;
         if (gb != 0 && gb != pgb) begin
            if (lastb != 0)
               chk("t6_alt", {4'b0, gb},
                   (lastb == 4'b0010) ? 8'h08 : 8'h02);
            lastb = gb;
            nb++;
         end
         pgb = gb;
      end
      chk("t6_handovers", {7'b0, nb >= 4}, 8'h01);

      // random traffic on both instances
      rnd_tick = 1;
      for (int i = 0; i < 500; i++) begin
         step();
         if ($urandom_range(0, 3) == 0) bus_a.i_req = 4'($urandom);
         if ($urandom_range(0, 3) == 0) bus_b.i_req = 4'($urandom);
         if ($urandom_range(0, 7) == 0) bus_a.i_color = 12'($urandom);
         if ($urandom_range(0, 7) == 0) bus_b.i_color = 12'($urandom);
         if (i == 250) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end
endmodule
